// File: rtl/mem_stage_w_pkg.sv
// Shared definitions for the Y86 memory stage: instruction codes, status
// codes, register sentinel, datapath widths, FSM encoding, the W-register
// payload and small instruction-classification helpers.
package mem_stage_w_pkg;

  localparam int unsigned WORD   = 32;
  localparam int unsigned NIBBLE = 4;
  localparam int unsigned STAT_W = 3;

  // Instruction codes
  localparam logic [NIBBLE-1:0] I_HALT   = 4'h0;
  localparam logic [NIBBLE-1:0] I_NOP    = 4'h1;
  localparam logic [NIBBLE-1:0] I_RRMOVL = 4'h2;
  localparam logic [NIBBLE-1:0] I_IRMOVL = 4'h3;
  localparam logic [NIBBLE-1:0] I_RMMOVL = 4'h4;
  localparam logic [NIBBLE-1:0] I_MRMOVL = 4'h5;
  localparam logic [NIBBLE-1:0] I_OPL    = 4'h6;
  localparam logic [NIBBLE-1:0] I_JXX    = 4'h7;
  localparam logic [NIBBLE-1:0] I_CALL   = 4'h8;
  localparam logic [NIBBLE-1:0] I_RET    = 4'h9;
  localparam logic [NIBBLE-1:0] I_PUSHL  = 4'hA;
  localparam logic [NIBBLE-1:0] I_POPL   = 4'hB;

  // Status codes
  localparam logic [STAT_W-1:0] S_AOK = 3'd1;
  localparam logic [STAT_W-1:0] S_HLT = 3'd2;
  localparam logic [STAT_W-1:0] S_ADR = 3'd3;
  localparam logic [STAT_W-1:0] S_INS = 3'd4;

  // No-register sentinel
  localparam logic [NIBBLE-1:0] RNONE = 4'hF;

  // Memory-access FSM
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // W pipeline register payload
  typedef struct packed {
    logic [NIBBLE-1:0] icode;
    logic [STAT_W-1:0] stat;
    logic [WORD-1:0]   valE;
    logic [WORD-1:0]   valM;
    logic [NIBBLE-1:0] dstE;
    logic [NIBBLE-1:0] dstM;
    logic              cnd;
  } w_reg_t;

  localparam w_reg_t W_NOP = '{
    icode: I_NOP,
    stat:  S_AOK,
    valE:  '0,
    valM:  '0,
    dstE:  RNONE,
    dstM:  RNONE,
    cnd:   1'b0
  };

  function automatic logic is_mem_read(input logic [NIBBLE-1:0] icode);
    return (icode == I_MRMOVL) || (icode == I_POPL) || (icode == I_RET);
  endfunction

  function automatic logic is_mem_write(input logic [NIBBLE-1:0] icode);
    return (icode == I_RMMOVL) || (icode == I_PUSHL) || (icode == I_CALL);
  endfunction

endpackage

// File: rtl/mem_stage_w_if.sv
// Data-memory request/acknowledge bus.
//   req   : request, held until ack
//   we    : 1 = write
//   addr  : byte address
//   wdata : write data
//   ack   : access complete
//   err   : access faulted, qualified by ack
//   rdata : read data, valid with ack
// master = memory stage, slave = data memory.
interface mem_stage_w_if;
  import mem_stage_w_pkg::*;

  logic            req;
  logic            we;
  logic [WORD-1:0] addr;
  logic [WORD-1:0] wdata;
  logic            ack;
  logic            err;
  logic [WORD-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, err, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, err, rdata
  );

endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage control: classifies the M-stage instruction, selects address
// and write data, range-checks the address, runs the IDLE/REQ access FSM
// with latched request fields, and produces stall, read value and status.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   M_icode_i, M_stat_i      : instruction code, upstream status
//   M_valA_i/valP_i/valE_i   : operands
//   mem_if (master)          : data-memory bus
//   m_stall_o                : combinational upstream hold
//   m_valM_o                 : combinational read result
//   m_stat_o                 : combinational stage status
module mem_stage_ctrl
  import mem_stage_w_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NIBBLE-1:0] M_icode_i,
  input  logic [STAT_W-1:0] M_stat_i,
  input  logic [WORD-1:0]   M_valA_i,
  input  logic [WORD-1:0]   M_valP_i,
  input  logic [WORD-1:0]   M_valE_i,
  mem_stage_w_if.master     mem_if,
  output logic              m_stall_o,
  output logic [WORD-1:0]   m_valM_o,
  output logic [STAT_W-1:0] m_stat_o
);

  // Highest legal word address
  localparam logic [WORD-1:0] ADDR_MAX = WORD'(MEM_BYTES - 4);

  state_e          state_q, state_d;
  logic [WORD-1:0] addr_q, addr_d;
  logic [WORD-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;

  logic            rd_c, wr_c, mem_op_c, addr_bad_c, issue_c, done_c;
  logic [WORD-1:0] addr_c, wdata_c;

  // Classification, address/data selection and range check
  always_comb begin
    rd_c       = is_mem_read(M_icode_i);
    wr_c       = is_mem_write(M_icode_i);
    mem_op_c   = rd_c || wr_c;
    addr_c     = ((M_icode_i == I_POPL) || (M_icode_i == I_RET)) ? M_valA_i : M_valE_i;
    wdata_c    = (M_icode_i == I_CALL) ? M_valP_i : M_valA_i;
    addr_bad_c = mem_op_c && (addr_c > ADDR_MAX);
    issue_c    = mem_op_c && (M_stat_i == S_AOK) && !addr_bad_c;
    done_c     = (state_q == ST_REQ) && mem_if.ack;
  end

  // Access FSM: next state, latched request fields, stall
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    m_stall_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (issue_c) begin
          m_stall_o = 1'b1;
          state_d   = ST_REQ;
          addr_d    = addr_c;
          wdata_d   = wdata_c;
          we_d      = wr_c;
        end
      end
      ST_REQ: begin
        if (mem_if.ack) begin
          state_d = ST_IDLE;
        end else begin
          m_stall_o = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read result: only a clean read completion returns data
  always_comb begin
    m_valM_o = '0;
    if (done_c && !we_q && !mem_if.err) begin
      m_valM_o = mem_if.rdata;
    end
  end

  // Stage status priority: upstream fault, address fault, halt, ok
  always_comb begin
    m_stat_o = S_AOK;
    if (M_stat_i != S_AOK) begin
      m_stat_o = M_stat_i;
    end else if (addr_bad_c || (done_c && mem_if.err)) begin
      m_stat_o = S_ADR;
    end else if (M_icode_i == I_HALT) begin
      m_stat_o = S_HLT;
    end
  end

  // Request is a decode of the state register so reset withdraws it at once
  assign mem_if.req   = (state_q == ST_REQ);
  assign mem_if.we    = we_q;
  assign mem_if.addr  = addr_q;
  assign mem_if.wdata = wdata_q;

  // State and latched request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

endmodule

// File: rtl/mem_stage_w.sv
// Y86 memory stage plus M->W pipeline register.
// Ports:
//   clk, rst                        : clock, async active-high reset
//   W_bubble_i                      : force a nop into W
//   M_icode_i, M_stat_i             : M-register instruction and status
//   M_valA_i, M_valP_i, M_valE_i    : operands
//   M_dstE_i, M_dstM_i, M_Cnd_i     : destinations, branch condition
//   mem_if (master)                 : data-memory request/ack bus
//   m_stall_o, m_valM_o, m_stat_o   : combinational stall/forwarding outputs
//   W_*_o                           : W register
module mem_stage_w
  import mem_stage_w_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              W_bubble_i,
  input  logic [NIBBLE-1:0] M_icode_i,
  input  logic [STAT_W-1:0] M_stat_i,
  input  logic [WORD-1:0]   M_valA_i,
  input  logic [WORD-1:0]   M_valP_i,
  input  logic [WORD-1:0]   M_valE_i,
  input  logic [NIBBLE-1:0] M_dstE_i,
  input  logic [NIBBLE-1:0] M_dstM_i,
  input  logic              M_Cnd_i,
  mem_stage_w_if.master     mem_if,
  output logic              m_stall_o,
  output logic [WORD-1:0]   m_valM_o,
  output logic [STAT_W-1:0] m_stat_o,
  output logic [NIBBLE-1:0] W_icode_o,
  output logic [STAT_W-1:0] W_stat_o,
  output logic [WORD-1:0]   W_valE_o,
  output logic [WORD-1:0]   W_valM_o,
  output logic [NIBBLE-1:0] W_dstE_o,
  output logic [NIBBLE-1:0] W_dstM_o,
  output logic              W_Cnd_o
);

  w_reg_t w_q, w_d;

  mem_stage_ctrl #(
    .MEM_BYTES (MEM_BYTES)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .M_icode_i (M_icode_i),
    .M_stat_i  (M_stat_i),
    .M_valA_i  (M_valA_i),
    .M_valP_i  (M_valP_i),
    .M_valE_i  (M_valE_i),
    .mem_if    (mem_if),
    .m_stall_o (m_stall_o),
    .m_valM_o  (m_valM_o),
    .m_stat_o  (m_stat_o)
  );

  // W next value: a stalled instruction is not passed on, so it writes back once
  always_comb begin
    w_d = W_NOP;
    if (!W_bubble_i && !m_stall_o) begin
      w_d.icode = M_icode_i;
      w_d.stat  = m_stat_o;
      w_d.valE  = M_valE_i;
      w_d.valM  = m_valM_o;
      w_d.dstE  = M_dstE_i;
      w_d.dstM  = M_dstM_i;
      w_d.cnd   = M_Cnd_i;
    end
  end

  // W register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q <= W_NOP;
    end else begin
      w_q <= w_d;
    end
  end

  assign W_icode_o = w_q.icode;
  assign W_stat_o  = w_q.stat;
  assign W_valE_o  = w_q.valE;
  assign W_valM_o  = w_q.valM;
  assign W_dstE_o  = w_q.dstE;
  assign W_dstM_o  = w_q.dstM;
  assign W_Cnd_o   = w_q.cnd;

endmodule
